// File: rtl/mac_serial2d_pkg.sv
// Shared types and helpers for the 2D 4b-serial MAC sequencer.
// Covers operand modes, sequencer states and the per-step control word.
package mac_serial2d_pkg;

  typedef enum logic [2:0] {
    MODE_8X8 = 3'b000,
    MODE_8X4 = 3'b001,
    MODE_4X4 = 3'b111
  } mode_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_RUN,
    ST_FLUSH,
    ST_WAIT,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic w_sel;
    logic a_sel;
    logic sign_ctr;
    logic shift_ctr;
  } step_ctl_t;

  localparam int unsigned STEPS_8X8 = 4;
  localparam int unsigned STEPS_8X4 = 2;
  localparam int unsigned STEPS_4X4 = 1;

  function automatic logic mode_is_legal(input logic [2:0] m);
    return (m == 3'b000) || (m == 3'b001) || (m == 3'b111);
  endfunction

  // Illegal encodings fall back to the full 8x8 sequence.
  function automatic mode_t legal_mode(input logic [2:0] m);
    case (m)
      3'b001:  return MODE_8X4;
      3'b111:  return MODE_4X4;
      default: return MODE_8X8;
    endcase
  endfunction

endpackage

// File: rtl/mac_serial2d_steprom.sv
// Digit-step control table: maps (mode, step index) to the MAC control word
// and flags the final step of a product.
module mac_serial2d_steprom
  import mac_serial2d_pkg::*;
(
  input  mode_t       mode_i,
  input  logic [1:0]  step_i,
  output step_ctl_t   ctl_o,
  output logic        last_o
);

  always_comb begin
    ctl_o  = '0;
    last_o = 1'b0;
    case (mode_i)
      MODE_8X4: begin
        last_o = (step_i == 2'(STEPS_8X4 - 1));
        case (step_i)
          2'd0:    ctl_o = step_ctl_t'(4'b0011);
          2'd1:    ctl_o = step_ctl_t'(4'b0111);
          default: ctl_o = '0;
        endcase
      end
      MODE_4X4: begin
        last_o = (step_i == 2'(STEPS_4X4 - 1));
        ctl_o  = (step_i == 2'd0) ? step_ctl_t'(4'b0011) : '0;
      end
      default: begin
        // Weight high nibble is the only signed digit; low-low needs no sign.
        last_o = (step_i == 2'(STEPS_8X8 - 1));
        case (step_i)
          2'd0:    ctl_o = step_ctl_t'(4'b0001);
          2'd1:    ctl_o = step_ctl_t'(4'b0100);
          2'd2:    ctl_o = step_ctl_t'(4'b1011);
          default: ctl_o = step_ctl_t'(4'b1111);
        endcase
      end
    endcase
  end

endmodule

// File: rtl/mac_serial2d_seq.sv
// Sequencer for the 2D 4b-serial MAC: accepts operand pairs, issues one digit
// step per clk_fast cycle, accumulates n_acc products and flushes the sum into z.
module mac_serial2d_seq
  import mac_serial2d_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int PIPE_LAT = 2
) (
  input  logic             clk_fast,
  input  logic             rst,
  input  logic [2:0]       mode_i,
  input  logic             start_i,
  input  logic [CNT_W-1:0] n_acc_i,
  input  logic             op_valid_i,
  output logic             op_ready_o,
  input  logic [7:0]       w_in_i,
  input  logic [7:0]       a_in_i,
  output logic [7:0]       w_o,
  output logic [7:0]       a_o,
  output logic             w_sel_o,
  output logic             a_sel_o,
  output logic             sign_ctr_o,
  output logic             shift_ctr_o,
  output logic             rst_mult_o,
  output logic             slow_en_o,
  output logic             mac_rst_o,
  output logic             busy_o,
  output logic             res_valid_o,
  output logic             mode_err_o
);

  localparam int WAIT_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  state_t             state_q, state_d;
  mode_t              mode_q, mode_d;
  logic [CNT_W-1:0]   n_acc_q, n_acc_d;
  logic [CNT_W-1:0]   prod_cnt_q, prod_cnt_d;
  logic [1:0]         step_q, step_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic               full_q, full_d;
  logic [7:0]         w_q, w_d;
  logic [7:0]         a_q, a_d;
  logic               err_q, err_d;

  step_ctl_t          step_ctl;
  step_ctl_t          ctl;
  logic               last_step;
  logic               last_prod;
  logic               run_rdy;
  logic               load;

  mac_serial2d_steprom u_steprom (
    .mode_i (mode_q),
    .step_i (step_q),
    .ctl_o  (step_ctl),
    .last_o (last_step)
  );

  // Refill either into an empty register or underneath the last step of a
  // product that is not the final one, so products run back to back.
  assign last_prod = (prod_cnt_q == n_acc_q - CNT_W'(1));
  assign run_rdy   = (state_q == ST_RUN) && (!full_q || (last_step && !last_prod));
  assign load      = op_valid_i && run_rdy;

  assign op_ready_o  = run_rdy;
  assign w_sel_o     = ctl.w_sel;
  assign a_sel_o     = ctl.a_sel;
  assign sign_ctr_o  = ctl.sign_ctr;
  assign shift_ctr_o = ctl.shift_ctr;
  assign slow_en_o   = rst_mult_o;
  assign mode_err_o  = err_q;

  always_ff @(posedge clk_fast) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      mode_q     <= MODE_8X8;
      n_acc_q    <= '0;
      prod_cnt_q <= '0;
      step_q     <= '0;
      wait_q     <= '0;
      full_q     <= 1'b0;
      w_q        <= '0;
      a_q        <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      n_acc_q    <= n_acc_d;
      prod_cnt_q <= prod_cnt_d;
      step_q     <= step_d;
      wait_q     <= wait_d;
      full_q     <= full_d;
      w_q        <= w_d;
      a_q        <= a_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    n_acc_d     = n_acc_q;
    prod_cnt_d  = prod_cnt_q;
    step_d      = step_q;
    wait_d      = wait_q;
    full_d      = full_q;
    w_d         = w_q;
    a_d         = a_q;
    err_d       = err_q;
    w_o         = '0;
    a_o         = '0;
    ctl         = '0;
    rst_mult_o  = 1'b0;
    mac_rst_o   = 1'b0;
    res_valid_o = 1'b0;
    busy_o      = (state_q != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          mode_d     = legal_mode(mode_i);
          err_d      = !mode_is_legal(mode_i);
          n_acc_d    = n_acc_i;
          prod_cnt_d = '0;
          step_d     = '0;
          full_d     = 1'b0;
          state_d    = ST_CLR;
        end
      end
      ST_CLR: begin
        mac_rst_o = 1'b1;
        state_d   = (n_acc_q == '0) ? ST_FLUSH : ST_RUN;
      end
      ST_RUN: begin
        if (load) begin
          w_d = w_in_i;
          a_d = a_in_i;
        end
        // An empty register is a bubble: zero operands, no controls asserted.
        if (full_q) begin
          w_o        = w_q;
          a_o        = a_q;
          ctl        = step_ctl;
          rst_mult_o = (step_q == 2'd0);
          if (last_step) begin
            step_d     = '0;
            prod_cnt_d = prod_cnt_q + CNT_W'(1);
            full_d     = load;
            if (last_prod) state_d = ST_FLUSH;
          end else begin
            step_d = step_q + 2'd1;
          end
        end else begin
          full_d = load;
        end
      end
      ST_FLUSH: begin
        rst_mult_o = 1'b1;
        wait_d     = '0;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        if (wait_q == WAIT_W'(PIPE_LAT - 1)) state_d = ST_DONE;
        else wait_d = wait_q + WAIT_W'(1);
      end
      ST_DONE: begin
        res_valid_o = 1'b1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mac_serial2d_seq.sv
// Self-checking bench for mac_serial2d_seq: directed jobs plus randomized jobs
// checked cycle by cycle against the step tables and plain product arithmetic.
module tb_mac_serial2d_seq;
  localparam int CNT_W    = 8;
  localparam int PIPE_LAT = 2;

  logic             clk_fast = 1'b0;
  logic             rst = 1'b1;
  logic [2:0]       mode_i = '0;
  logic             start_i = 1'b0;
  logic [CNT_W-1:0] n_acc_i = '0;
  logic             op_valid_i = 1'b0;
  logic             op_ready_o;
  logic [7:0]       w_in_i = '0;
  logic [7:0]       a_in_i = '0;
  logic [7:0]       w_o, a_o;
  logic             w_sel_o, a_sel_o, sign_ctr_o, shift_ctr_o;
  logic             rst_mult_o, slow_en_o, mac_rst_o, busy_o, res_valid_o, mode_err_o;

  int   total = 0;
  int   bad = 0;
  logic errExp = 1'b0;
  logic [7:0] fixW[$];
  logic [7:0] fixA[$];

  mac_serial2d_seq #(.CNT_W(CNT_W), .PIPE_LAT(PIPE_LAT)) dut (
    .clk_fast(clk_fast), .rst(rst), .mode_i(mode_i), .start_i(start_i), .n_acc_i(n_acc_i),
    .op_valid_i(op_valid_i), .op_ready_o(op_ready_o), .w_in_i(w_in_i), .a_in_i(a_in_i),
    .w_o(w_o), .a_o(a_o), .w_sel_o(w_sel_o), .a_sel_o(a_sel_o), .sign_ctr_o(sign_ctr_o),
    .shift_ctr_o(shift_ctr_o), .rst_mult_o(rst_mult_o), .slow_en_o(slow_en_o),
    .mac_rst_o(mac_rst_o), .busy_o(busy_o), .res_valid_o(res_valid_o), .mode_err_o(mode_err_o)
  );

  always #5 clk_fast = ~clk_fast;

  task automatic tick();
    @(posedge clk_fast);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] obsCtl();
    return {w_sel_o, a_sel_o, sign_ctr_o, shift_ctr_o, rst_mult_o, slow_en_o,
            mac_rst_o, busy_o, res_valid_o, op_ready_o};
  endfunction

  function automatic logic [9:0] expCtl(input logic [3:0] sc, input logic rm, input logic mr,
                                        input logic bz, input logic rv, input logic rdy);
    return {sc, rm, rm, mr, bz, rv, rdy};
  endfunction

  function automatic int stepsOf(input int em);
    return (em == 1) ? 2 : (em == 7) ? 1 : 4;
  endfunction

  // Step control tables {w_sel,a_sel,sign_ctr,shift_ctr}.
  function automatic logic [3:0] tblCtl(input int em, input int s);
    if (em == 7) return 4'b0011;
    if (em == 1) return (s == 0) ? 4'b0011 : 4'b0111;
    case (s)
      0:       return 4'b0001;
      1:       return 4'b0100;
      2:       return 4'b1011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic int refProd(input int em, input logic [7:0] w, input logic [7:0] a);
    int wv, av;
    wv = (em == 0) ? int'($signed(w)) : int'($signed(w[3:0]));
    av = (em == 7) ? int'(a[3:0]) : int'(a);
    return wv * av;
  endfunction

  // Partial product the MAC forms from the digits and controls presented this cycle.
  function automatic int decodeStep();
    logic [3:0] wn, an;
    int wv, sh;
    wn = w_sel_o ? w_o[7:4] : w_o[3:0];
    an = a_sel_o ? a_o[7:4] : a_o[3:0];
    wv = sign_ctr_o ? int'($signed(wn)) : int'(wn);
    sh = 4 * (int'(w_sel_o) + int'(a_sel_o));
    return wv * int'(an) * (1 << sh);
  endfunction

  task automatic applyStimulus(input string tag, input logic [2:0] m, input int n,
                               input int gapAt, input int gapLen, input int abortStep);
    logic [7:0] wArr[$];
    logic [7:0] aArr[$];
    logic legal;
    int em, sc, bub, prod, sum, expSum;
    legal = (m == 3'b000) || (m == 3'b001) || (m == 3'b111);
    em = legal ? int'(m) : 0;
    sc = stepsOf(em);
    sum = 0;
    expSum = 0;
    for (int k = 0; k < n; k++) begin
      if (fixW.size() > 0) begin
        wArr.push_back(fixW.pop_front());
        aArr.push_back(fixA.pop_front());
      end else begin
        wArr.push_back(8'($urandom));
        aArr.push_back(8'($urandom));
      end
    end
    start_i = 1'b1;
    mode_i = m;
    n_acc_i = CNT_W'(n);
    op_valid_i = (n > 0);
    if (n > 0) begin
      w_in_i = wArr[0];
      a_in_i = aArr[0];
    end
    tick();
    errExp = !legal;
    checkOutput({tag, " clr"}, 32'(obsCtl()), 32'(expCtl(4'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0)));
    checkOutput({tag, " mode_err"}, 32'(mode_err_o), 32'(errExp));
    start_i = 1'b0;
    for (int k = 0; k < n; k++) begin
      bub = (k == 0) ? 1 : ((k == gapAt) ? gapLen : 0);
      for (int b = 0; b < bub; b++) begin
        tick();
        checkOutput({tag, " bubble"}, 32'(obsCtl()), 32'(expCtl(4'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1)));
        checkOutput({tag, " bubble wa"}, 32'({w_o, a_o}), 32'(0));
        op_valid_i = (b == bub - 1);
        w_in_i = (b == bub - 1) ? wArr[k] : 8'($urandom);
        a_in_i = (b == bub - 1) ? aArr[k] : 8'($urandom);
      end
      prod = 0;
      for (int s = 0; s < sc; s++) begin
        tick();
        checkOutput({tag, " step"}, 32'(obsCtl()),
                    32'(expCtl(tblCtl(em, s), s == 0, 1'b0, 1'b1, 1'b0, (s == sc - 1) && (k < n - 1))));
        checkOutput({tag, " step wa"}, 32'({w_o, a_o}), 32'({wArr[k], aArr[k]}));
        prod += decodeStep();
        if (k == 0 && s == abortStep) begin
          rst = 1'b1;
          start_i = 1'b0;
          op_valid_i = 1'b0;
          tick();
          errExp = 1'b0;
          checkOutput({tag, " abort"}, 32'(obsCtl()), 32'(0));
          checkOutput({tag, " abort wa"}, 32'({w_o, a_o, 7'b0, mode_err_o}), 32'(0));
          rst = 1'b0;
          return;
        end
        if (s == sc - 1 && k < n - 1 && (k + 1) != gapAt) begin
          op_valid_i = 1'b1;
          w_in_i = wArr[k + 1];
          a_in_i = aArr[k + 1];
        end else if (s == sc - 1 && k < n - 1) begin
          op_valid_i = 1'b0;
        end else begin
          op_valid_i = 1'($urandom);
          w_in_i = 8'($urandom);
          a_in_i = 8'($urandom);
          start_i = 1'($urandom);
          mode_i = 3'b010;
        end
      end
      checkOutput({tag, " product"}, 32'(prod), 32'(refProd(em, wArr[k], aArr[k])));
      sum += prod;
      expSum += refProd(em, wArr[k], aArr[k]);
    end
    tick();
    checkOutput({tag, " flush"}, 32'(obsCtl()), 32'(expCtl(4'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0)));
    checkOutput({tag, " flush wa"}, 32'({w_o, a_o}), 32'(0));
    start_i = 1'b0;
    op_valid_i = 1'b0;
    for (int i = 0; i < PIPE_LAT; i++) begin
      tick();
      checkOutput({tag, " wait"}, 32'(obsCtl()), 32'(expCtl(4'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0)));
      op_valid_i = (i == PIPE_LAT - 1);
    end
    tick();
    checkOutput({tag, " done"}, 32'(obsCtl()), 32'(expCtl(4'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0)));
    op_valid_i = 1'b0;
    tick();
    checkOutput({tag, " idle"}, 32'(obsCtl()), 32'(0));
    checkOutput({tag, " z"}, 32'(sum), 32'(expSum));
    checkOutput({tag, " mode_err end"}, 32'(mode_err_o), 32'(errExp));
  endtask

  initial begin
    logic [2:0] modes[4];
    modes[0] = 3'b000;
    modes[1] = 3'b001;
    modes[2] = 3'b111;
    modes[3] = 3'b101;
    rst = 1'b1;
    tick();
    tick();
    checkOutput("reset ctl", 32'(obsCtl()), 32'(0));
    checkOutput("reset wa", 32'({w_o, a_o, 7'b0, mode_err_o}), 32'(0));
    rst = 1'b0;

    fixW = '{8'hFD};
    fixA = '{8'd200};
    applyStimulus("t1_8x8", 3'b000, 1, 0, 0, -1);

    fixW = '{8'd7, 8'hF8, 8'd1, 8'hFF};
    fixA = '{8'd15, 8'd15, 8'd1, 8'd2};
    applyStimulus("t2_4x4", 3'b111, 4, 0, 0, -1);

    applyStimulus("t3_8x4_gap", 3'b001, 3, 1, 2, -1);
    applyStimulus("t4_nzero", 3'b000, 0, 0, 0, -1);
    applyStimulus("t5_abort", 3'b000, 2, 0, 0, 2);
    applyStimulus("t5_after", 3'b000, 2, 0, 0, -1);
    applyStimulus("t6_illegal", 3'b010, 2, 1, 1, -1);
    applyStimulus("t6_legal", 3'b111, 2, 0, 0, -1);
    applyStimulus("nmax_4x4", 3'b111, 255, 100, 3, -1);

    for (int r = 0; r < 12; r++) begin
      applyStimulus("rand", modes[$urandom_range(0, 3)], $urandom_range(1, 5),
                    $urandom_range(1, 4), $urandom_range(1, 3), -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
